// File: rtl/conv_mem_arbiter_pkg.sv
// Shared constants and helpers for the layer-result memory arbiter.
// Bank-select encodings follow the csel pins; requester indices fix arbitration priority order.
package conv_mem_arbiter_pkg;

  typedef logic [2:0] csel_t;

  localparam csel_t CSEL_NONE = 3'd0;
  localparam csel_t CSEL_L0   = 3'd1;
  localparam csel_t CSEL_L1   = 3'd3;

  localparam int REQ_CONV = 0;
  localparam int REQ_POOL = 1;
  localparam int REQ_HOST = 2;

  // A beat addressed to no bank is granted but never reaches the memory pins
  function automatic logic csel_valid(input csel_t s);
    return s != CSEL_NONE;
  endfunction

endpackage

// File: rtl/conv_mem_arbiter_if.sv
// Requester command/return bus plus the single-port memory pins.
// master = engines and memory side, slave = the arbiter.
interface conv_mem_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 12,
  parameter int DW    = 20
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         we;
  logic [N_REQ-1:0]         lock;
  logic [N_REQ-1:0][2:0]    sel;
  logic [N_REQ-1:0][AW-1:0] addr;
  logic [N_REQ-1:0][DW-1:0] wdata;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [DW-1:0]            rdata;
  logic                     err;
  logic                     crd;
  logic                     cwr;
  logic [AW-1:0]            caddr_rd;
  logic [AW-1:0]            caddr_wr;
  logic [DW-1:0]            cdata_wr;
  logic [2:0]               csel;
  logic [DW-1:0]            cdata_rd;

  modport master (
    output req, we, lock, sel, addr, wdata, cdata_rd,
    input  gnt, rvalid, rdata, err, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel
  );

  modport slave (
    input  req, we, lock, sel, addr, wdata, cdata_rd,
    output gnt, rvalid, rdata, err, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/conv_mem_arbiter_rr_arbiter.sv
// N-way round-robin picker: the first requester after the last winner wins,
// unless the lock owner is still requesting. Grant is combinational.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_i,
  input  logic          lock_vld_i,
  input  logic [IW-1:0] lock_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] win_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic [N-1:0]  pick;
  logic          found;

  always_comb begin
    pick  = '0;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        win       = idx;
      end
    end
    // An active burst keeps its owner regardless of where the pointer sits
    if (lock_vld_i && req_i[lock_idx_i]) begin
      pick             = '0;
      pick[lock_idx_i] = 1'b1;
      win              = lock_idx_i;
    end
  end

  assign gnt_o = reset_n ? pick : '0;
  assign win_o = win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ptr_q <= IW'(N - 1);
    else if (|pick) ptr_q <= win;
  end

endmodule

// File: rtl/conv_mem_arbiter.sv
// Shares the single-port L0/L1 result memory between conv, pool and host requesters:
// one registered access per cycle, locked bursts with a beat cap, tagged read return.
module conv_mem_arbiter
  import conv_mem_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input logic               clk,
  input logic               reset_n,
  conv_mem_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    win;
  logic             acc;
  logic             w_we;
  logic             w_lock;
  csel_t            w_sel;
  logic             w_ok;
  logic             iss_rd;
  logic             iss_wr;

  logic             lk_vld_q, lk_vld_d;
  logic [IW-1:0]    lk_idx_q, lk_idx_d;
  logic [CW-1:0]    lk_cnt_q, lk_cnt_d;
  logic [CW-1:0]    lk_base;
  logic [CW-1:0]    lk_nxt;

  logic             crd_q, cwr_q, err_q;
  csel_t            csel_q;
  logic [AW-1:0]    caddr_rd_q, caddr_wr_q;
  logic [DW-1:0]    cdata_wr_q;
  logic [RD_LAT:0][N_REQ-1:0] rtag_q, rtag_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_i      (bus.req),
    .lock_vld_i (lk_vld_q),
    .lock_idx_i (lk_idx_q),
    .gnt_o      (gnt),
    .win_o      (win)
  );

  assign acc    = |gnt;
  assign w_we   = bus.we[win];
  assign w_lock = bus.lock[win];
  assign w_sel  = bus.sel[win];
  assign w_ok   = csel_valid(w_sel);
  assign iss_rd = acc && w_ok && !w_we;
  assign iss_wr = acc && w_ok && w_we;

  // Burst tracking: count consecutive locked beats by one owner; the cap beat
  // drops the lock so the next arbitration follows the pointer.
  always_comb begin
    lk_vld_d = 1'b0;
    lk_idx_d = lk_idx_q;
    lk_cnt_d = '0;
    lk_base  = '0;
    lk_nxt   = '0;
    if (acc) begin
      lk_idx_d = win;
      lk_base  = (lk_vld_q && (lk_idx_q == win)) ? lk_cnt_q : '0;
      lk_nxt   = lk_base + 1'b1;
      if (w_lock && (lk_nxt < CW'(LOCK_MAX))) begin
        lk_vld_d = 1'b1;
        lk_cnt_d = lk_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_vld_q <= 1'b0;
      lk_idx_q <= '0;
      lk_cnt_q <= '0;
    end else begin
      lk_vld_q <= lk_vld_d;
      lk_idx_q <= lk_idx_d;
      lk_cnt_q <= lk_cnt_d;
    end
  end

  // Read tags ride alongside crd and then RD_LAT more stages to meet cdata_rd
  always_comb begin
    rtag_d = {rtag_q[RD_LAT-1:0], (iss_rd ? gnt : {N_REQ{1'b0}})};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      err_q      <= 1'b0;
      csel_q     <= CSEL_NONE;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      rtag_q     <= '0;
    end else begin
      crd_q  <= iss_rd;
      cwr_q  <= iss_wr;
      err_q  <= acc && !w_ok;
      csel_q <= acc ? w_sel : CSEL_NONE;
      rtag_q <= rtag_d;
      if (iss_rd) caddr_rd_q <= bus.addr[win];
      if (iss_wr) begin
        caddr_wr_q <= bus.addr[win];
        cdata_wr_q <= bus.wdata[win];
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rvalid   = rtag_q[RD_LAT];
  assign bus.rdata    = (|rtag_q[RD_LAT]) ? bus.cdata_rd : '0;
  assign bus.err      = err_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed bench for conv_mem_arbiter: a per-cycle vector table plus hand-written
// sequences for tagged read return, locked-burst cap and mid-read reset.
module tb_conv_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  conv_mem_arbiter_if #(.N_REQ(3), .AW(12), .DW(20)) bus ();

  conv_mem_arbiter #(.N_REQ(3), .AW(12), .DW(20), .RD_LAT(2), .LOCK_MAX(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory model: read data is a fixed function of the address, two cycles after crd
  function automatic logic [19:0] memf(input logic [11:0] a);
    return {a[7:0] ^ 8'hA5, a};
  endfunction

  logic [19:0] rp0 = '0;
  logic [19:0] rp1 = '0;
  always @(posedge clk) begin
    if (bus.crd) rp0 <= memf(bus.caddr_rd);
    rp1 <= rp0;
  end
  assign bus.cdata_rd = rp1;

  typedef struct {
    logic [2:0]  req, we;
    logic [8:0]  sel;
    logic [11:0] paddr;
    logic [19:0] pwd;
    logic [2:0]  gnt;
    logic        crd, cwr;
    logic [2:0]  csel;
    logic        err;
    logic [2:0]  rv;
    logic [11:0] ard, awr;
    logic [19:0] dwr;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, we, input logic [8:0] sel,
                              input logic [11:0] paddr, input logic [19:0] pwd,
                              input logic [2:0] gnt, input logic crd, cwr,
                              input logic [2:0] csel, input logic err, input logic [2:0] rv,
                              input logic [11:0] ard, awr, input logic [19:0] dwr);
    vec_t v;
    v.req = req; v.we = we; v.sel = sel; v.paddr = paddr; v.pwd = pwd;
    v.gnt = gnt; v.crd = crd; v.cwr = cwr; v.csel = csel; v.err = err; v.rv = rv;
    v.ard = ard; v.awr = awr; v.dwr = dwr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] S   = 9'b001_001_001;
  localparam logic [8:0] S9  = 9'b001_011_001;
  localparam logic [8:0] S11 = 9'b000_001_001;

  vec_t tbl[22];
  int   pool_n;
  int   conv_n;
  logic [2:0] eg;

  initial begin
    // round-robin reads, pool write, sel==0 error beat, partial-request rotation
    tbl[0]  = mk(3'b111, 3'b000, S,   12'h020, 20'h0,     3'b001, 0, 0, 3'd0, 0, 3'b000, 12'h000, 12'h000, 20'h00000);
    tbl[1]  = mk(3'b111, 3'b000, S,   12'h020, 20'h0,     3'b010, 1, 0, 3'd1, 0, 3'b000, 12'h010, 12'h000, 20'h00000);
    tbl[2]  = mk(3'b111, 3'b000, S,   12'h020, 20'h0,     3'b100, 1, 0, 3'd1, 0, 3'b000, 12'h020, 12'h000, 20'h00000);
    tbl[3]  = mk(3'b111, 3'b000, S,   12'h020, 20'h0,     3'b001, 1, 0, 3'd1, 0, 3'b001, 12'h030, 12'h000, 20'h00000);
    tbl[4]  = mk(3'b111, 3'b000, S,   12'h020, 20'h0,     3'b010, 1, 0, 3'd1, 0, 3'b010, 12'h010, 12'h000, 20'h00000);
    tbl[5]  = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 1, 0, 3'd1, 0, 3'b100, 12'h020, 12'h000, 20'h00000);
    tbl[6]  = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b001, 12'h020, 12'h000, 20'h00000);
    tbl[7]  = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b010, 12'h020, 12'h000, 20'h00000);
    tbl[8]  = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h000, 20'h00000);
    tbl[9]  = mk(3'b010, 3'b010, S9,  12'h041, 20'h00ABC, 3'b010, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h000, 20'h00000);
    tbl[10] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 1, 3'd3, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[11] = mk(3'b100, 3'b000, S11, 12'h020, 20'h0,     3'b100, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[12] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 1, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[13] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[14] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[15] = mk(3'b110, 3'b000, S,   12'h020, 20'h0,     3'b010, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[16] = mk(3'b110, 3'b000, S,   12'h020, 20'h0,     3'b100, 1, 0, 3'd1, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);
    tbl[17] = mk(3'b110, 3'b000, S,   12'h020, 20'h0,     3'b010, 1, 0, 3'd1, 0, 3'b000, 12'h030, 12'h041, 20'h00ABC);
    tbl[18] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 1, 0, 3'd1, 0, 3'b010, 12'h020, 12'h041, 20'h00ABC);
    tbl[19] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b100, 12'h020, 12'h041, 20'h00ABC);
    tbl[20] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b010, 12'h020, 12'h041, 20'h00ABC);
    tbl[21] = mk(3'b000, 3'b000, S,   12'h020, 20'h0,     3'b000, 0, 0, 3'd0, 0, 3'b000, 12'h020, 12'h041, 20'h00ABC);

    bus.req = '0; bus.we = '0; bus.lock = '0; bus.sel = S;
    bus.addr = '0; bus.wdata = '0;
    #1;
    chk("rst gnt",      32'(bus.gnt), 32'h0);
    chk("rst rvalid",   32'(bus.rvalid), 32'h0);
    chk("rst rdata",    32'(bus.rdata), 32'h0);
    chk("rst crd/cwr",  32'({bus.crd, bus.cwr, bus.err}), 32'h0);
    chk("rst csel",     32'(bus.csel), 32'h0);
    chk("rst addr",     32'({bus.caddr_rd, bus.caddr_wr}), 32'h0);
    chk("rst cdata_wr", 32'(bus.cdata_wr), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      tick();
      bus.req   = tbl[i].req;
      bus.we    = tbl[i].we;
      bus.lock  = '0;
      bus.sel   = tbl[i].sel;
      bus.addr  = {12'h030, tbl[i].paddr, 12'h010};
      bus.wdata = {20'h0, tbl[i].pwd, 20'h0};
      @(negedge clk);
      chk($sformatf("v%0d gnt", i),      32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d crd", i),      32'(bus.crd), 32'(tbl[i].crd));
      chk($sformatf("v%0d cwr", i),      32'(bus.cwr), 32'(tbl[i].cwr));
      chk($sformatf("v%0d csel", i),     32'(bus.csel), 32'(tbl[i].csel));
      chk($sformatf("v%0d err", i),      32'(bus.err), 32'(tbl[i].err));
      chk($sformatf("v%0d rvalid", i),   32'(bus.rvalid), 32'(tbl[i].rv));
      chk($sformatf("v%0d caddr_rd", i), 32'(bus.caddr_rd), 32'(tbl[i].ard));
      chk($sformatf("v%0d caddr_wr", i), 32'(bus.caddr_wr), 32'(tbl[i].awr));
      chk($sformatf("v%0d cdata_wr", i), 32'(bus.cdata_wr), 32'(tbl[i].dwr));
      if (tbl[i].rv != 3'b000)
        chk($sformatf("v%0d rdata", i), 32'(bus.rdata),
            32'(memf(tbl[i].rv == 3'b001 ? 12'h010 : (tbl[i].rv == 3'b010 ? 12'h020 : 12'h030))));
    end

    // Back-to-back reads from conv then host return in issue order, tagged
    tick(); bus.req = 3'b001; bus.we = '0; bus.sel = S; bus.addr = {12'd9, 12'h020, 12'd5};
    @(negedge clk); chk("b2b gnt conv", 32'(bus.gnt), 32'h1);
    tick(); bus.req = 3'b100;
    @(negedge clk); chk("b2b gnt host", 32'(bus.gnt), 32'h4);
    tick(); bus.req = 3'b000;
    @(negedge clk); chk("b2b early rvalid", 32'(bus.rvalid), 32'h0);
    tick();
    @(negedge clk); chk("b2b rvalid conv", 32'(bus.rvalid), 32'h1);
    chk("b2b rdata conv", 32'(bus.rdata), 32'(memf(12'd5)));
    tick();
    @(negedge clk); chk("b2b rvalid host", 32'(bus.rvalid), 32'h4);
    chk("b2b rdata host", 32'(bus.rdata), 32'(memf(12'd9)));

    // Pool locked write burst of 20 beats against a waiting conv reader
    pool_n = 0; conv_n = 0;
    for (int c = 0; c < 40 && pool_n < 20; c++) begin
      tick();
      bus.req[1] = 1'b1; bus.lock[1] = 1'b1; bus.we[1] = 1'b1; bus.sel[1] = 3'd3;
      bus.req[0] = (c > 0) && (conv_n == 0);
      @(negedge clk);
      eg = (c == 16) ? 3'b001 : 3'b010;
      chk($sformatf("burst c%0d gnt", c), 32'(bus.gnt), 32'(eg));
      if (bus.gnt[1]) pool_n++;
      if (bus.gnt[0]) conv_n++;
    end
    chk("burst pool beats", 32'(pool_n), 32'd20);
    chk("burst conv beats", 32'(conv_n), 32'd1);
    tick(); bus.req = '0; bus.lock = '0; bus.we = '0; bus.sel = S;
    repeat (4) tick();

    // Reset while a read is in flight
    tick(); bus.req = 3'b001; bus.addr = {12'h030, 12'h020, 12'h055};
    @(negedge clk); chk("rstrd gnt", 32'(bus.gnt), 32'h1);
    tick(); chk("rstrd crd", 32'(bus.crd), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstrd gnt0",   32'(bus.gnt), 32'h0);
    chk("rstrd crd0",   32'({bus.crd, bus.cwr, bus.err}), 32'h0);
    chk("rstrd csel0",  32'(bus.csel), 32'h0);
    chk("rstrd addr0",  32'(bus.caddr_rd), 32'h0);
    chk("rstrd rvalid", 32'(bus.rvalid), 32'h0);
    repeat (2) @(posedge clk);
    #1 bus.req = '0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("post-rst rvalid %0d", i), 32'(bus.rvalid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
